// File: rtl/hs_dpath_lat_adapter.sv
// hs_dpath_lat_adapter: valid/ready wrapper around a fixed-latency, clock-enabled pipe.
// A valid-bit chain shadows the external pipe. Its output is captured into a credit-protected
// FIFO and re-emitted as a valid/ready stream.
// Build option: define HS_DPATH_LAT_ADAPT_CE_GATE_EN to gate pipe_ce while the pipe holds no
// tokens. When it is undefined, pipe_ce is held high outside reset.
module hs_dpath_lat_adapter #(
  parameter type         DATA_TYPE  = logic,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  DATA_TYPE                         s_data,
  output logic                             pipe_ce,
  output DATA_TYPE                         pipe_din,
  input  DATA_TYPE                         pipe_dout,
  output logic                             m_valid,
  input  logic                             m_ready,
  output DATA_TYPE                         m_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  occupancy,
  output logic                             idle
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DepthC  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LastPtr = PW'(FIFO_DEPTH - 1);

  logic                srst_q;
  logic [LATENCY-1:0]  vld_q, vld_d;
  logic [CW-1:0]       outstanding_q, outstanding_d;
  logic [CW-1:0]       occ_q, occ_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  DATA_TYPE            mem_q [FIFO_DEPTH];

  logic acc, pop, push;

  assign m_valid   = (occ_q != '0);
  assign pop       = m_valid & m_ready;
  // Credits cover in-flight tokens plus FIFO entries. A pop this cycle frees one slot.
  // The live srst term keeps s_ready low during the first reset cycle as well.
  assign s_ready   = !srst & !srst_q & ((outstanding_q < DepthC) | pop);
  assign acc       = s_valid & s_ready;
`ifdef HS_DPATH_LAT_ADAPT_CE_GATE_EN
  assign pipe_ce   = !srst & (acc | (|vld_q));
`else
  assign pipe_ce   = !srst;
`endif
  assign push      = vld_q[LATENCY-1] & pipe_ce;
  assign pipe_din  = s_data;
  assign m_data    = mem_q[rd_ptr_q];
  assign occupancy = occ_q;
  assign idle      = (outstanding_q == '0);

  // Next-state: valid chain, credit and occupancy counters, FIFO pointers.
  always_comb begin
    vld_d         = vld_q;
    outstanding_d = outstanding_q + CW'(acc) - CW'(pop);
    occ_d         = occ_q + CW'(push) - CW'(pop);
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (pipe_ce) begin
      vld_d[0] = acc;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  // Control state with synchronous reset; srst_q stretches s_ready low by one cycle.
  always_ff @(posedge clk) begin
    srst_q <= srst;
    if (srst) begin
      vld_q         <= '0;
      outstanding_q <= '0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      vld_q         <= vld_d;
      outstanding_q <= outstanding_d;
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO payload storage. It has no reset because entries are only read while valid.
  always_ff @(posedge clk) begin
    if (push && !srst) begin
      mem_q[wr_ptr_q] <= pipe_dout;
    end
  end

endmodule

// File: tb/tb_hs_dpath_lat_adapter.sv
// Directed bench for hs_dpath_lat_adapter.
// Instance a uses LATENCY=3, FIFO_DEPTH=4. Instance b uses LATENCY=4, FIFO_DEPTH=2.
// Both instances wrap a behavioural clock-enabled shift-register pipe.
module tb_hs_dpath_lat_adapter;

`ifdef HS_DPATH_LAT_ADAPT_CE_GATE_EN
  localparam bit CeGate = 1'b1;
`else
  localparam bit CeGate = 1'b0;
`endif

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Instance a
  logic       a_s_valid, a_s_ready, a_pipe_ce, a_m_valid, a_m_ready, a_idle;
  logic [7:0] a_s_data, a_pipe_din, a_pipe_dout, a_m_data;
  logic [2:0] a_occ;
  logic [7:0] a_pipe_q [3];

  // Instance b
  logic       b_s_valid, b_s_ready, b_pipe_ce, b_m_valid, b_m_ready, b_idle;
  logic [7:0] b_s_data, b_pipe_din, b_pipe_dout, b_m_data;
  logic [1:0] b_occ;
  logic [7:0] b_pipe_q [4];

  hs_dpath_lat_adapter #(
    .DATA_TYPE (logic [7:0]),
    .LATENCY   (3),
    .FIFO_DEPTH(4)
  ) u_a (
    .clk      (clk),
    .srst     (srst),
    .s_valid  (a_s_valid),
    .s_ready  (a_s_ready),
    .s_data   (a_s_data),
    .pipe_ce  (a_pipe_ce),
    .pipe_din (a_pipe_din),
    .pipe_dout(a_pipe_dout),
    .m_valid  (a_m_valid),
    .m_ready  (a_m_ready),
    .m_data   (a_m_data),
    .occupancy(a_occ),
    .idle     (a_idle)
  );

  hs_dpath_lat_adapter #(
    .DATA_TYPE (logic [7:0]),
    .LATENCY   (4),
    .FIFO_DEPTH(2)
  ) u_b (
    .clk      (clk),
    .srst     (srst),
    .s_valid  (b_s_valid),
    .s_ready  (b_s_ready),
    .s_data   (b_s_data),
    .pipe_ce  (b_pipe_ce),
    .pipe_din (b_pipe_din),
    .pipe_dout(b_pipe_dout),
    .m_valid  (b_m_valid),
    .m_ready  (b_m_ready),
    .m_data   (b_m_data),
    .occupancy(b_occ),
    .idle     (b_idle)
  );

  // Behavioural fixed-latency pipes
  always @(posedge clk) begin
    if (a_pipe_ce) begin
      a_pipe_q[0] <= a_pipe_din;
      a_pipe_q[1] <= a_pipe_q[0];
      a_pipe_q[2] <= a_pipe_q[1];
    end
    if (b_pipe_ce) begin
      b_pipe_q[0] <= b_pipe_din;
      b_pipe_q[1] <= b_pipe_q[0];
      b_pipe_q[2] <= b_pipe_q[1];
      b_pipe_q[3] <= b_pipe_q[2];
    end
  end
  assign a_pipe_dout = a_pipe_q[2];
  assign b_pipe_dout = b_pipe_q[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int sent;
  logic exp_rdy, exp_mv;

  initial begin
    srst = 1'b1;
    a_s_valid = 1'b1; a_s_data = 8'h55; a_m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_data = 8'h00; b_m_ready = 1'b1;

    // ---- Reset held 3 cycles with s_valid high ----
    #1 chk("rst_s_ready_pre", a_s_ready, 0);
    for (int r = 0; r < 3; r++) begin
      step();
      chk("rst_s_ready", a_s_ready, 0);
      chk("rst_m_valid", a_m_valid, 0);
      chk("rst_occ", a_occ, 0);
      chk("rst_idle", a_idle, 1);
      chk("rst_pipe_ce", a_pipe_ce, 0);
      chk("rst_b_s_ready", b_s_ready, 0);
      chk("rst_b_idle", b_idle, 1);
    end
    srst = 1'b0;
    #1 chk("rst_s_ready_after", a_s_ready, 0);
    step();
    a_s_valid = 1'b0;
    #1 chk("rst_s_ready_open", a_s_ready, 1);
    chk("rst_m_valid_open", a_m_valid, 0);

    // ---- Streaming 0x01..0x10, m_ready=1 ----
    a_s_valid = 1'b1; a_s_data = 8'h01;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c < 16) chk("stream_s_ready", a_s_ready, 1);
      step();
      chk("stream_m_valid", a_m_valid, 32'(c >= 3 && c <= 18));
      if (c >= 3 && c <= 18) chk("stream_m_data", a_m_data, 32'(c - 2));
      a_s_valid = (c + 1 < 16);
      a_s_data  = 8'(c + 2);
    end
    chk("stream_idle", a_idle, 1);

    // ---- Back-pressure: m_ready=0, continuous s_valid ----
    a_m_ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      a_s_valid = 1'b1;
      a_s_data  = 8'(8'h20 + j);
      #1 chk("bp_s_ready", a_s_ready, 32'(j < 4));
      step();
      chk("bp_occ", a_occ, 32'((j >= 3) ? ((j - 2 > 4) ? 4 : j - 2) : 0));
      if (j >= 3) begin
        chk("bp_m_valid", a_m_valid, 1);
        chk("bp_m_data_hold", a_m_data, 32'h20);
      end
    end
    a_s_valid = 1'b0;
    a_m_ready = 1'b1;
    #1 chk("bp_s_ready_on_pop", a_s_ready, 1);
    for (int d = 0; d < 4; d++) begin
      chk("drain_m_valid", a_m_valid, 1);
      chk("drain_m_data", a_m_data, 32'(8'h20 + d));
      step();
    end
    chk("drain_empty", a_m_valid, 0);
    chk("drain_idle", a_idle, 1);

    // ---- Mid-flight reset: 2 in flight, 1 in FIFO ----
    a_m_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      a_s_valid = 1'b1;
      a_s_data  = 8'(8'h31 + t);
      step();
    end
    a_s_valid = 1'b0;
    step();
    chk("mid_occ_before", a_occ, 1);
    chk("mid_idle_before", a_idle, 0);
    srst = 1'b1;
    step();
    chk("mid_occ_rst", a_occ, 0);
    chk("mid_m_valid_rst", a_m_valid, 0);
    chk("mid_idle_rst", a_idle, 1);
    srst = 1'b0;
    #1 chk("mid_s_ready_after", a_s_ready, 0);
    a_m_ready = 1'b1;
    step();
    a_s_valid = 1'b1;
    a_s_data  = 8'hAA;
    #1 chk("mid_s_ready_open", a_s_ready, 1);
    step();
    a_s_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("mid_m_valid", a_m_valid, 32'(c == 3));
      if (c == 3) chk("mid_m_data", a_m_data, 32'hAA);
      step();
    end
    chk("mid_idle_end", a_idle, 1);

    // ---- CE gating: idle 10 cycles, then one token ----
    for (int i = 0; i < 10; i++) begin
      #1 chk("ce_idle", a_pipe_ce, 32'(!CeGate));
      step();
    end
    a_s_valid = 1'b1;
    a_s_data  = 8'h5A;
    #1 chk("ce_acc", a_pipe_ce, 1);
    step();
    a_s_valid = 1'b0;
    // Gated: ce covers the accept cycle plus one cycle per valid-chain stage.
    for (int c = 0; c < 6; c++) begin
      chk("ce_token", a_pipe_ce, 32'(!CeGate || c < 3));
      chk("ce_m_valid", a_m_valid, 32'(c == 3));
      if (c == 3) chk("ce_m_data", a_m_data, 32'h5A);
      step();
    end

    // ---- Undersized FIFO on instance b: 2 tokens per 5 cycles ----
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      b_s_valid = 1'b1;
      b_s_data  = 8'(8'h40 + sent);
      exp_rdy   = (c % 5) < 2;
      #1 chk("us_s_ready", b_s_ready, 32'(exp_rdy));
      step();
      if (exp_rdy) sent++;
      exp_mv = (c >= 4) && ((c % 5 == 4) || (c % 5 == 0));
      chk("us_m_valid", b_m_valid, 32'(exp_mv));
      if (exp_mv) chk("us_m_data", b_m_data, 32'(8'h40 + 2 * ((c - 4) / 5) + (c - 4) % 5));
    end
    b_s_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("us_idle_end", b_idle, 1);
    chk("us_occ_end", b_occ, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
